// File: rtl/cc_capture_pkg.sv
// rtl/cc_capture_pkg.sv - shared state encoding, header magic and lane helper for the capture path
package cc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } cap_state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hF5A0;

  function automatic int lanes_of(input int out_w, input int pix_w);
    return out_w / pix_w;
  endfunction

endpackage

// File: rtl/cc_pixel_packer.sv
// rtl/cc_pixel_packer.sv - lane shift register packing PIX_W pixels into OUT_W words, lane 0 in the low bits
module cc_pixel_packer
  import cc_capture_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic             flush,
  input  logic [PIX_W-1:0] data,
  output logic [OUT_W-1:0] word,
  output logic             word_ready,
  output logic             pending,
  output logic             at_last
);

  localparam int LANES = lanes_of(OUT_W, PIX_W);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0]    k;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] merged;

  always_comb begin
    merged = acc;
    merged[int'(k)*PIX_W +: PIX_W] = data;
  end

  assign at_last = (k == LW'(LANES - 1));
  assign pending = (k != '0);

  // acc is zeroed after every emitted word so a flushed partial word has clean upper lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      acc        <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        k   <= '0;
        acc <= '0;
      end else if (valid) begin
        if (at_last) begin
          word       <= merged;
          word_ready <= 1'b1;
          k          <= '0;
          acc        <= '0;
        end else begin
          acc <= merged;
          k   <= k + 1'b1;
        end
      end else if (flush && pending) begin
        word       <= acc;
        word_ready <= 1'b1;
        k          <= '0;
        acc        <= '0;
      end
    end
  end

endmodule

// File: rtl/cc_frame_packer.sv
// rtl/cc_frame_packer.sv - vsync-framed pixel capture into FIFO words with frame statistics
// Optional frame header word enabled by defining CC_FRAME_HEADER_EN.
module cc_frame_packer
  import cc_capture_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             cmos_clk_i,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] cmos_data_i,
  input  logic             cmos_vsync_i,
  input  logic             cmos_hsync_i,
  input  logic             cmos_valid_i,
  output logic             cmos_reset_o,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             fifo_full,
  output logic [OUT_W-1:0] data_out,
  output logic             we,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_pixels,
  output logic [CNT_W-1:0] frame_lines,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  cap_state_e state, state_nx;

  logic             vs_s1, hs_s1, vld_s1, vs_s2, hs_s2;
  logic [PIX_W-1:0] dat_s1;
  logic [CNT_W-1:0] pix_cnt, line_cnt, pix_cnt_nx, line_cnt_nx;
  logic             vs_rise, vs_fall, hs_rise;
  logic             pix_valid, pk_clear, pk_flush, partial_nx, fd_set;
  logic [OUT_W-1:0] pk_word;
  logic             pk_ready, pk_pending, pk_at_last;
  logic             wr_pend;

  assign cmos_reset_o = ~rst_n;

  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1  <= 1'b0;
      hs_s1  <= 1'b0;
      vld_s1 <= 1'b0;
      dat_s1 <= '0;
      vs_s2  <= 1'b0;
      hs_s2  <= 1'b0;
    end else begin
      vs_s1  <= cmos_vsync_i;
      hs_s1  <= cmos_hsync_i;
      vld_s1 <= cmos_valid_i;
      dat_s1 <= cmos_data_i;
      vs_s2  <= vs_s1;
      hs_s2  <= hs_s1;
    end
  end

  assign vs_rise   = vs_s1 & ~vs_s2;
  assign vs_fall   = ~vs_s1 & vs_s2;
  assign hs_rise   = hs_s1 & ~hs_s2;
  assign pix_valid = (state == ST_CAPTURE) & vld_s1;
  assign pk_clear  = abort | (state == ST_IDLE) | (state == ST_ARM);
  assign pk_flush  = (state == ST_FLUSH);
  // lane occupancy after this edge decides whether the frame ends with a partial word
  assign partial_nx = pix_valid ? ~pk_at_last : pk_pending;

  cc_pixel_packer #(
    .PIX_W(PIX_W),
    .OUT_W(OUT_W)
  ) u_packer (
    .clk       (cmos_clk_i),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .valid     (pix_valid),
    .flush     (pk_flush),
    .data      (dat_s1),
    .word      (pk_word),
    .word_ready(pk_ready),
    .pending   (pk_pending),
    .at_last   (pk_at_last)
  );

  always_comb begin
    state_nx = state;
    fd_set   = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state_nx = ST_ARM;
        ST_ARM:     if (vs_rise) state_nx = ST_CAPTURE;
        ST_CAPTURE: begin
          if (vs_fall) begin
            state_nx = ST_FLUSH;
            fd_set   = ~partial_nx;
          end
        end
        ST_FLUSH: begin
          state_nx = cont ? ST_ARM : ST_IDLE;
          fd_set   = pk_pending;
        end
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pix_cnt_nx  = pix_cnt;
    line_cnt_nx = line_cnt;
    if (state == ST_IDLE || state == ST_ARM) begin
      pix_cnt_nx  = '0;
      line_cnt_nx = '0;
    end else if (state == ST_CAPTURE) begin
      if (vld_s1 && pix_cnt != CNT_MAX) pix_cnt_nx = pix_cnt + 1'b1;
      if (hs_rise && vs_s1 && line_cnt != CNT_MAX) line_cnt_nx = line_cnt + 1'b1;
    end
  end

  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      frame_lines  <= '0;
      overflow     <= 1'b0;
    end else begin
      state      <= state_nx;
      pix_cnt    <= pix_cnt_nx;
      line_cnt   <= line_cnt_nx;
      frame_done <= fd_set;
      if (fd_set) begin
        frame_pixels <= pix_cnt_nx;
        frame_lines  <= line_cnt_nx;
      end
      if (state == ST_IDLE && start && !abort) overflow <= 1'b0;
      else if (wr_pend && fifo_full)           overflow <= 1'b1;
    end
  end

`ifdef CC_FRAME_HEADER_EN
  logic        hdr_q;
  logic [15:0] seq;

  if (OUT_W < 32) begin : g_hdr_width_check
    $error("cc_frame_packer: header needs OUT_W >= 32");
  end

  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q <= 1'b0;
      seq   <= '0;
    end else begin
      hdr_q <= (state == ST_ARM) && vs_rise && !abort;
      if (fd_set) seq <= seq + 1'b1;
    end
  end

  assign wr_pend  = pk_ready | hdr_q;
  assign data_out = hdr_q ? OUT_W'({HDR_MAGIC, seq}) : pk_word;
`else
  assign wr_pend  = pk_ready;
  assign data_out = pk_word;
`endif

  assign we   = wr_pend & ~fifo_full;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cc_frame_packer.sv
// tb/tb_cc_frame_packer.sv - randomized frame stimulus against a cycle-timed queue model of cc_frame_packer
module tb_cc_frame_packer;

  localparam int PIX_W = 16;
  localparam int OUT_W = 32;
  localparam int CNT_W = 8;
  localparam int LANES = OUT_W / PIX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef CC_FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic             cmos_clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic [PIX_W-1:0] cmos_data_i = '0;
  logic             cmos_vsync_i = 1'b0, cmos_hsync_i = 1'b0, cmos_valid_i = 1'b0;
  logic             cmos_reset_o;
  logic             start = 1'b0, cont = 1'b0, abort = 1'b0, fifo_full = 1'b0;
  logic [OUT_W-1:0] data_out;
  logic             we, busy, frame_done, overflow;
  logic [CNT_W-1:0] frame_pixels, frame_lines;

  cc_frame_packer #(.PIX_W(PIX_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .cmos_clk_i  (cmos_clk_i),
    .rst_n       (rst_n),
    .cmos_data_i (cmos_data_i),
    .cmos_vsync_i(cmos_vsync_i),
    .cmos_hsync_i(cmos_hsync_i),
    .cmos_valid_i(cmos_valid_i),
    .cmos_reset_o(cmos_reset_o),
    .start       (start),
    .cont        (cont),
    .abort       (abort),
    .fifo_full   (fifo_full),
    .data_out    (data_out),
    .we          (we),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .frame_lines (frame_lines),
    .overflow    (overflow)
  );

  always #5 cmos_clk_i = ~cmos_clk_i;

  int cyc = 0;
  always @(posedge cmos_clk_i) cyc <= cyc + 1;

  typedef struct { int c; logic [OUT_W-1:0] d; } wr_t;
  typedef struct { int c; int px; int ln; } fd_t;
  wr_t              wq[$];
  fd_t              fq[$];
  logic [OUT_W-1:0] wr_log[$];
  int               checks = 0, errors = 0, fd_cnt = 0;
  int               seq_m = 0, force_full_c = -1, full_pct = 0;
  int               last_px = 0, last_ln = 0;
  bit               ovf_m = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // every cycle: writes and frame_done must occur exactly when the model scheduled them
  always @(negedge cmos_clk_i) begin : cmp
    bit ew, efd;
    logic [OUT_W-1:0] ed;
    fd_t f;
    ew = 1'b0;
    ed = '0;
    if (wq.size() > 0 && wq[0].c == cyc) begin
      ed = wq[0].d;
      void'(wq.pop_front());
      if (fifo_full) ovf_m = 1'b1;
      else ew = 1'b1;
    end
    chk("we", we, ew);
    if (ew) chk("data_out", data_out, ed);
    if (we) wr_log.push_back(data_out);
    efd = (fq.size() > 0 && fq[0].c == cyc);
    chk("frame_done", frame_done, efd);
    if (efd) begin
      f = fq.pop_front();
      chk("frame_pixels", frame_pixels, f.px);
      chk("frame_lines", frame_lines, f.ln);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge cmos_clk_i);
    #1;
    fifo_full = (cyc == force_full_c) || (full_pct > 0 && int'($urandom_range(99)) < full_pct);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    ovf_m = 1'b0;
    repeat (3) tick();
  endtask

  task automatic reset_checks();
    chk("rst_cmos_reset_o", cmos_reset_o, 1'b1);
    chk("rst_data_out", data_out, '0);
    chk("rst_we", we, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_pixels", frame_pixels, '0);
    chk("rst_frame_lines", frame_lines, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
  endtask

  // kind: 0 none, 1 abort before kill_line, 2 reset before kill_line, 3 start while vsync high
  task automatic run_frame(input int nl, input int ppl, input bit ramp, input int gapmax,
                           input bit modeled, input int kill_line, input int kind, input int force_idx);
    int lane, npix, nwords, pidx, f;
    logic [OUT_W-1:0] acc, hw;
    logic [PIX_W-1:0] d;
    bit m;
    m = modeled; lane = 0; npix = 0; nwords = 0; pidx = 0; acc = '0;
    cmos_vsync_i = 1'b1;
    if (m && HDR == 1) begin
      hw = '0;
      hw[31:0] = {16'hF5A0, 16'(seq_m)};
      wq.push_back('{cyc + 2, hw});
    end
    tick();
    tick();
    if (kind == 3) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      ovf_m = 1'b0;
    end
    for (int l = 0; l < nl; l++) begin
      if (m && l == kill_line && kind == 1) begin
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m = 1'b0;
      end else if (m && l == kill_line && kind == 2) begin
        repeat (2) tick();
        rst_n = 1'b0;
        wq.delete();
        fq.delete();
        ovf_m = 1'b0;
        seq_m = 0;
        #1;
        reset_checks();
        tick();
        rst_n = 1'b1;
        m = 1'b0;
      end
      cmos_hsync_i = 1'b1;
      for (int p = 0; p < ppl; p++) begin
        repeat ($urandom_range(gapmax)) begin
          cmos_valid_i = 1'b0;
          tick();
        end
        d = ramp ? PIX_W'(pidx + 1) : PIX_W'($urandom);
        pidx++;
        cmos_valid_i = 1'b1;
        cmos_data_i  = d;
        if (m) begin
          acc[lane*PIX_W +: PIX_W] = d;
          npix++;
          lane++;
          if (lane == LANES) begin
            if (nwords == force_idx) force_full_c = cyc + 2;
            wq.push_back('{cyc + 2, acc});
            nwords++;
            acc  = '0;
            lane = 0;
          end
        end
        tick();
      end
      cmos_valid_i = 1'b0;
      cmos_hsync_i = 1'b0;
      cmos_data_i  = '0;
      tick();
      tick();
    end
    cmos_vsync_i = 1'b0;
    if (m) begin
      f = cyc;
      last_px = sat(npix);
      last_ln = sat(nl);
      if (lane != 0) begin
        wq.push_back('{f + 3, acc});
        fq.push_back('{f + 3, last_px, last_ln});
      end else begin
        fq.push_back('{f + 2, last_px, last_ln});
      end
      seq_m++;
    end
    repeat (6) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int fd0, fp0;
    repeat (3) tick();
    reset_checks();
    rst_n = 1'b1;
    tick();

    // 4 lines x 6 ramp pixels
    wr_log.delete();
    do_start();
    run_frame(4, 6, 1'b1, 0, 1'b1, -1, 0, -1);
    chk("t1_writes", wr_log.size(), 12 + HDR);
    chk("t1_first_word", wr_log[HDR], 32'h0002_0001);
    chk("t1_frame_pixels", frame_pixels, 24);
    chk("t1_frame_lines", frame_lines, 4);
    chk("t1_frame_done_cnt", fd_cnt, 1);
    chk("t1_busy", busy, 1'b0);
`ifdef CC_FRAME_HEADER_EN
    chk("t1_header", wr_log[0], 32'hF5A0_0000);
`endif

    // 5 pixels: partial last word
    wr_log.delete();
    do_start();
    run_frame(1, 5, 1'b1, 1, 1'b1, -1, 0, -1);
    chk("t2_writes", wr_log.size(), 3 + HDR);
    chk("t2_last_word", wr_log[wr_log.size()-1], 32'h0000_0005);
    chk("t2_frame_pixels", frame_pixels, 5);
`ifdef CC_FRAME_HEADER_EN
    chk("t2_header", wr_log[0], 32'hF5A0_0001);
`endif

    // fifo_full on the second pixel word's write cycle
    wr_log.delete();
    do_start();
    chk("t3_overflow_pre", overflow, 1'b0);
    run_frame(2, 4, 1'b1, 0, 1'b1, -1, 0, 1);
    force_full_c = -1;
    chk("t3_writes", wr_log.size(), 3 + HDR);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_frame_pixels", frame_pixels, 8);
    do_start();
    chk("t3_overflow_cleared", overflow, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // continuous capture over 3 frames with random backpressure
    full_pct = 10;
    fd0 = fd_cnt;
    cont = 1'b1;
    do_start();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cont = 1'b0;
      run_frame($urandom_range(5, 1), $urandom_range(9, 1), 1'b0, 2, 1'b1, -1, 0, -1);
    end
    chk("t4_cont_frames", fd_cnt - fd0, 3);
    chk("t4_busy", busy, 1'b0);
    chk("t4_overflow", overflow, ovf_m);

    // start while vsync high: first frame ignored, next captured
    fd0 = fd_cnt;
    run_frame(3, 4, 1'b0, 1, 1'b0, -1, 3, -1);
    chk("t5_armed_busy", busy, 1'b1);
    chk("t5_no_done", fd_cnt - fd0, 0);
    run_frame(3, 5, 1'b0, 1, 1'b1, -1, 0, -1);
    chk("t5_done", fd_cnt - fd0, 1);

    // pixel counter saturation
    full_pct = 0;
    do_start();
    run_frame(2, 150, 1'b0, 0, 1'b1, -1, 0, -1);
    chk("t6_frame_pixels_sat", frame_pixels, CMAX);
    chk("t6_frame_lines", frame_lines, 2);

    // abort mid-capture
    full_pct = 10;
    fd0 = fd_cnt;
    fp0 = int'(frame_pixels);
    do_start();
    run_frame(4, 6, 1'b1, 1, 1'b1, 2, 1, -1);
    chk("t7_no_done", fd_cnt - fd0, 0);
    chk("t7_frame_pixels_kept", frame_pixels, fp0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_overflow_kept", overflow, ovf_m);

    // reset mid-frame, then a fresh capture
    do_start();
    run_frame(3, 5, 1'b0, 1, 1'b1, 1, 2, -1);
    chk("t8_busy", busy, 1'b0);
    chk("t8_frame_pixels", frame_pixels, 0);
    fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      do_start();
      run_frame($urandom_range(4, 1), $urandom_range(11, 1), 1'b0, 3, 1'b1, -1, 0, -1);
      chk("t9_overflow", overflow, ovf_m);
    end
    chk("t9_frames", fd_cnt - fd0, 4);
    chk("t9_last_pixels", frame_pixels, last_px);
    chk("end_pending_writes", wq.size(), 0);
    chk("end_pending_done", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
